// File: rtl/fir_input_sequencer.sv
// Feeds the 4-tap FIR: mode word, then coefficients high index first, then buffered samples.
// Outputs are registered-state Moore functions; the sample FIFO accepts pushes in every state.
module fir_input_sequencer #(
  parameter int BW_in      = 6,
  parameter int N_TAPS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coef_we,
  input  logic [1:0]                    coef_addr,
  input  logic [BW_in-1:0]              coef_wdata,
  input  logic                          lsb_mode,
  input  logic                          start,
  input  logic                          stop,
  input  logic [BW_in-1:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          fir_rst,
  output logic [BW_in-1:0]              x_out,
  output logic                          sample_slot,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MODE   = 2'd1;
  localparam logic [1:0] S_COEF   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             mode_q, mode_d;
  logic             underflow_q, underflow_d;
  logic [BW_in-1:0] coef_q [N_TAPS];
  logic [BW_in-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;

  logic full, empty, push, pop, flush, slot, coef_wr;

  assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign flush   = stop && (state_q != S_IDLE);
  // s_ready deliberately ignores a same-cycle pop
  assign push    = s_valid && !full && !flush;
  assign slot    = (state_q == S_STREAM) && (!mode_q || phase_q);
  assign pop     = slot && !empty;
  assign coef_wr = coef_we && (state_q == S_IDLE) && (int'(coef_addr) < N_TAPS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    underflow_d = underflow_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_MODE;
          mode_d      = lsb_mode;
          underflow_d = 1'b0;
        end
      end
      S_MODE: begin
        state_d = S_COEF;
        cnt_d   = CW'(N_TAPS - 1);
      end
      S_COEF: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_STREAM;
          phase_d = 1'b1;
        end
      end
      default: begin
        phase_d = ~phase_q;
        if (slot && empty) underflow_d = 1'b1;
      end
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      mode_q      <= 1'b0;
      underflow_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < N_TAPS; i++) coef_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
      if (coef_wr) coef_q[coef_addr] <= coef_wdata;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  // Storage needs no reset: the level counter defines which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    x_out = '0;
    case (state_q)
      S_MODE:   x_out = {{(BW_in-1){1'b0}}, mode_q};
      S_COEF:   x_out = coef_q[cnt_q];
      S_STREAM: if (pop) x_out = mem_q[rd_ptr_q];
      default:  x_out = '0;
    endcase
  end

  assign s_ready     = !full;
  assign fir_rst     = (state_q == S_IDLE);
  assign sample_slot = slot;
  assign underflow   = underflow_q;
  assign fifo_level  = level_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed bench for fir_input_sequencer; outputs are checked 1 time unit after each rising edge.
module tb_fir_input_sequencer;

  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          reset, coef_we, lsb_mode, start, stop, s_valid;
  logic [1:0]    coef_addr;
  logic [BW-1:0] coef_wdata, s_data;
  logic          s_ready, fir_rst, sample_slot, underflow, busy;
  logic [BW-1:0] x_out;
  logic [3:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  fir_input_sequencer #(.BW_in(BW), .N_TAPS(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .lsb_mode(lsb_mode), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .fir_rst(fir_rst),
    .x_out(x_out), .sample_slot(sample_slot), .underflow(underflow),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [1:0] a, input int v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = BW'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic push(input int v);
    s_valid = 1'b1; s_data = BW'(v);
    tick();
    s_valid = 1'b0;
  endtask

  // Issues start from IDLE, checks MODE and the four COEF beats, returns on the first STREAM cycle
  task automatic load_seq(input logic m, input int c3, input int c2, input int c1, input int c0);
    int exp_c [4];
    exp_c = '{c3, c2, c1, c0};
    start = 1'b1; lsb_mode = m;
    check("idle_fir_rst", fir_rst, 1);
    tick();
    start = 1'b0; lsb_mode = 1'b0;
    check("mode_fir_rst", fir_rst, 0);
    check("mode_busy", busy, 1);
    check("mode_word", $signed(x_out), m);
    check("mode_slot", sample_slot, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("coef_beat%0d", i), $signed(x_out), exp_c[i]);
      check("coef_slot", sample_slot, 0);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; lsb_mode = 1'b0;
    start = 1'b0; stop = 1'b0; s_data = '0; s_valid = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_fir_rst", fir_rst, 1);
    check("rst_x", $signed(x_out), 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underflow", underflow, 0);
    check("rst_slot", sample_slot, 0);
    reset = 1'b0;
    tick();

    // Normal mode load and stream, then underflow
    write_coef(2'd0, 1); write_coef(2'd1, 2); write_coef(2'd2, -3); write_coef(2'd3, 4);
    push(5); push(-6); push(7);
    check("prefill_level", fifo_level, 3);
    load_seq(1'b0, 4, -3, 2, 1);
    check("s0_x", $signed(x_out), 5);  check("s0_slot", sample_slot, 1); tick();
    check("s1_x", $signed(x_out), -6); check("s1_slot", sample_slot, 1); tick();
    check("s2_x", $signed(x_out), 7);  check("s2_slot", sample_slot, 1); tick();
    check("empty_level", fifo_level, 0);
    check("empty_x", $signed(x_out), 0);
    check("empty_slot", sample_slot, 1);
    check("uflow_pre", underflow, 0);
    tick();
    check("uflow_set", underflow, 1);
    check("uflow_x", $signed(x_out), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", busy, 0);
    check("uflow_sticky", underflow, 1);

    // LSB readout mode: samples only on every other cycle
    push(10); push(11); push(12);
    load_seq(1'b1, 4, -3, 2, 1);
    check("lsb_uflow_clr", underflow, 0);
    begin
      int ex [6] = '{10, 0, 11, 0, 12, 0};
      int sl [6] = '{1, 0, 1, 0, 1, 0};
      int lv [6] = '{3, 2, 2, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
        check($sformatf("lsb_x%0d", i), $signed(x_out), ex[i]);
        check($sformatf("lsb_slot%0d", i), sample_slot, sl[i]);
        check($sformatf("lsb_level%0d", i), fifo_level, lv[i]);
        tick();
      end
    end
    check("lsb_no_uflow", underflow, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Fill to capacity, ninth push refused; stop during COEF flushes
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1; s_data = BW'(i + 1);
      check($sformatf("fill_ready%0d", i), s_ready, (i < 8) ? 1 : 0);
      check($sformatf("fill_level%0d", i), fifo_level, (i < 8) ? i : 8);
      tick();
    end
    s_valid = 1'b0;
    check("full_level", fifo_level, 8);
    check("full_ready", s_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("abort_in_coef", busy, 1);
    check("abort_coef_x", $signed(x_out), 4);
    stop = 1'b1; s_valid = 1'b1; s_data = BW'(3);
    tick();
    stop = 1'b0; s_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_level", fifo_level, 0);
    check("abort_fir_rst", fir_rst, 1);

    // start with stop in IDLE is ignored; coef_we during STREAM is ignored
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    load_seq(1'b0, 4, -3, 2, 1);
    coef_we = 1'b1; coef_addr = 2'd3; coef_wdata = BW'(9);
    tick();
    coef_we = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    load_seq(1'b0, 4, -3, 2, 1);

    // Reset mid-stream clears everything including coefficients
    push(6);
    reset = 1'b1; tick();
    check("rst2_fir_rst", fir_rst, 1);
    check("rst2_x", $signed(x_out), 0);
    check("rst2_busy", busy, 0);
    check("rst2_s_ready", s_ready, 1);
    check("rst2_level", fifo_level, 0);
    check("rst2_underflow", underflow, 0);
    reset = 1'b0;
    tick();
    load_seq(1'b0, 0, 0, 0, 0);
    check("rst2_stream_x", $signed(x_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
